// File: rtl/riscv_pkg.sv
// Shared core types for the writeback path.
//   XLEN       - datapath width
//   REG_ADDR_W - register index width
//   wb_req_t   - one pending register-file write (destination + value)
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests, no bypass.
//   clk_i/rst_i      - clock, synchronous active-high reset (discards contents)
//   push_i/push_data_i - enqueue request; ignored while full (even if popping)
//   pop_i/head_o     - dequeue request / current head entry
//   full_o/empty_o   - occupancy flags from registered pointers
//   count_o          - occupancy 0..DEPTH
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  wb_req_t                  push_data_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  wb_req_t       mem_q [DEPTH];
  logic          do_push, do_pop;

  always_comb begin
    count_o = wptr_q - rptr_q;
    full_o  = (count_o == (PtrW + 1)'(DEPTH));
    empty_o = (wptr_q == rptr_q);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    head_o  = mem_q[rptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[PtrW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. Source A (single-cycle ALU) has fixed
// priority over source B (buffered load/mul results); B is forced after
// STARVE_LIMIT consecutive A grants while B is pending.
//   clk, rst                       - clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data  - source A request handshake
//   b_valid/b_ready/b_addr/b_data  - source B push into the FIFO
//   write_ctrl/write_addr/write_data - registered regfile write port (latency 1)
//   fifo_count                     - source-B FIFO occupancy
//   idle                           - FIFO empty and no write in flight
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_ADDR_W-1:0]  a_addr,
  input  logic [XLEN-1:0]        a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_ADDR_W-1:0]  b_addr,
  input  logic [XLEN-1:0]        b_data,
  output logic                   write_ctrl,
  output logic [REG_ADDR_W-1:0]  write_addr,
  output logic [XLEN-1:0]        write_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  wb_req_t               b_req, b_head, sel_req;
  logic                  fifo_full, fifo_empty, ne;
  logic                  force_b, grant_a, grant_b;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  write_ctrl_q, write_ctrl_d;
  logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;

  assign b_req.addr = b_addr;
  assign b_req.data = b_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (b_valid && b_ready),
    .push_data_i (b_req),
    .pop_i       (grant_b),
    .head_o      (b_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    ne      = !fifo_empty;
    force_b = ne && (starve_q == CntW'(STARVE_LIMIT));
    grant_b = ne && (force_b || !a_valid);
    grant_a = a_valid && !force_b;
    a_ready = !rst && !force_b;
    b_ready = !rst && !fifo_full;

    // force_b implies grant_b, so the counter never passes STARVE_LIMIT.
    starve_d = starve_q;
    if (grant_b || !ne) begin
      starve_d = '0;
    end else if (grant_a) begin
      starve_d = starve_q + 1'b1;
    end

    sel_req = grant_a ? '{addr: a_addr, data: a_data} : b_head;

    // Writes to x0 are consumed but never reach the register file.
    write_ctrl_d = (grant_a || grant_b) && (sel_req.addr != '0);
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant_a || grant_b) begin
      write_addr_d = sel_req.addr;
      write_data_d = sel_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      write_ctrl_q <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      starve_q     <= starve_d;
      write_ctrl_q <= write_ctrl_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_ctrl = write_ctrl_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign idle       = fifo_empty && !write_ctrl_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        write_ctrl;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [2:0]  fifo_count;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .write_ctrl (write_ctrl),
    .write_addr (write_addr),
    .write_data (write_data),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // One row: drive inputs, check handshake outputs before the edge,
  // then check the registered write port and occupancy after the edge.
  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_wc;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // A only
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,   1, 1, 1, 5,  32'hDEADBEEF, 0};
    vecs[1]  = '{0, 0,  0,            0, 0,  0,   1, 1, 0, 5,  32'hDEADBEEF, 0};
    // B only: first push not poppable until next cycle, then one write per cycle
    vecs[2]  = '{0, 0,  0,            1, 1,  1,   1, 1, 0, 5,  32'hDEADBEEF, 1};
    vecs[3]  = '{0, 0,  0,            1, 2,  2,   1, 1, 1, 1,  1,            1};
    vecs[4]  = '{0, 0,  0,            1, 3,  3,   1, 1, 1, 2,  2,            1};
    vecs[5]  = '{0, 0,  0,            1, 4,  4,   1, 1, 1, 3,  3,            1};
    vecs[6]  = '{0, 0,  0,            0, 0,  0,   1, 1, 1, 4,  4,            0};
    vecs[7]  = '{0, 0,  0,            0, 0,  0,   1, 1, 0, 4,  4,            0};
    // x0 write from A (consumed, no write) while B starts filling
    vecs[8]  = '{1, 0,  32'hAAAA0000, 1, 10, 100, 1, 1, 0, 0,  32'hAAAA0000, 1};
    // three A grants with B pending; FIFO fills to 4
    vecs[9]  = '{1, 6,  32'h66,       1, 11, 101, 1, 1, 1, 6,  32'h66,       2};
    vecs[10] = '{1, 7,  32'h77,       1, 12, 102, 1, 1, 1, 7,  32'h77,       3};
    vecs[11] = '{1, 8,  32'h88,       1, 13, 103, 1, 1, 1, 8,  32'h88,       4};
    // forced B: A stalled, full FIFO refuses push despite the pop
    vecs[12] = '{1, 9,  32'h99,       1, 14, 104, 0, 0, 1, 10, 100,          3};
    // A resumes; the retried push now lands
    vecs[13] = '{1, 9,  32'h99,       1, 14, 104, 1, 1, 1, 9,  32'h99,       4};
    vecs[14] = '{0, 0,  0,            0, 0,  0,   1, 0, 1, 11, 101,          3};

    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    #1;
    chk("rst_a_ready", {31'b0, a_ready}, 0);
    chk("rst_b_ready", {31'b0, b_ready}, 0);
    tick();
    tick();
    chk("rst_write_ctrl", {31'b0, write_ctrl}, 0);
    chk("rst_write_addr", {27'b0, write_addr}, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_fifo_count", {29'b0, fifo_count}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", {31'b0, idle}, 1);
    chk("post_rst_b_ready", {31'b0, b_ready}, 1);

    for (int i = 0; i < 15; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].e_ar});
      chk($sformatf("v%0d_b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].e_br});
      tick();
      chk($sformatf("v%0d_write_ctrl", i), {31'b0, write_ctrl}, {31'b0, vecs[i].e_wc});
      chk($sformatf("v%0d_write_addr", i), {27'b0, write_addr}, {27'b0, vecs[i].e_wa});
      chk($sformatf("v%0d_write_data", i), write_data, vecs[i].e_wd);
      chk($sformatf("v%0d_fifo_count", i), {29'b0, fifo_count}, {29'b0, vecs[i].e_cnt});
    end

    // Reset with three entries queued: all must be discarded.
    a_valid = 0; b_valid = 0;
    rst = 1'b1;
    #1;
    chk("midrst_a_ready", {31'b0, a_ready}, 0);
    chk("midrst_b_ready", {31'b0, b_ready}, 0);
    tick();
    chk("midrst_fifo_count", {29'b0, fifo_count}, 0);
    chk("midrst_write_ctrl", {31'b0, write_ctrl}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_quiet%0d", i), {31'b0, write_ctrl}, 0);
    end
    chk("midrst_idle", {31'b0, idle}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
